mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_cond_neg.sv | 16 +
 rtl/mdu_seq.sv | 195 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
// Op codes, FSM state constants and the iteration count used by mdu_seq.
// The divider datapath in mdu_seq is only built when MDU_DIV_EN is defined.
package mdu_pkg;

  // Operation encoding presented on the op port
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // FSM state type and encodings
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_CALC = 2'd1;
  localparam mdu_state_t ST_FIX  = 2'd2;

  // One CALC step per operand bit
  localparam int MDU_ITERS = 32;

  // MULT and DIV treat their operands as two's complement
  function automatic logic mdu_op_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  // DIV and DIVU use the divider datapath
  function automatic logic mdu_op_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// mdu_cond_neg: conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
module mdu_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  // Pass through, or invert-and-increment when neg is set
  always_comb begin
    dout = neg ? (~din + WIDTH'(1)) : din;
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32x32 multiply / 32/32 divide with start/busy/done.
// Fixed 33-cycle latency: one latch cycle, 32 CALC steps, one FIX cycle.
// Optional feature: define MDU_DIV_EN to build the restoring divider.
// Without it, DIV/DIVU jump straight to FIX, leave hi/lo alone and flag fault.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t           state_reg;
  logic [5:0]           cnt_reg;
  logic                 op_div_reg;
  logic [2*WIDTH-1:0]   acc_reg;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd_reg;    // multiplicand magnitude or divisor magnitude
  logic                 neg_q_reg;   // negate product / quotient
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic                 done_reg;
  logic                 fault_reg;

  logic                 op_signed;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   prod_fix;

`ifdef MDU_DIV_EN
  logic                 neg_r_reg;   // remainder follows dividend sign
  logic                 divz_reg;    // divisor was zero
  logic [WIDTH-1:0]     a_raw_reg;   // original dividend, returned on divide-by-zero
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
`endif

  assign op_signed = mdu_op_signed(op);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign fault     = fault_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  // Operand magnitudes for signed ops, taken straight from the ports at E0
  mdu_cond_neg #(.WIDTH(WIDTH)) u_abs_a (
    .din (srcA),
    .neg (op_signed & srcA[WIDTH-1]),
    .dout(a_abs)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_abs_b (
    .din (srcB),
    .neg (op_signed & srcB[WIDTH-1]),
    .dout(b_abs)
  );

  // Signed product correction over the full 64-bit accumulator
  mdu_cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
    .din (acc_reg),
    .neg (neg_q_reg),
    .dout(prod_fix)
  );

`ifdef MDU_DIV_EN
  // Quotient and remainder sign correction
  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
    .din (acc_reg[WIDTH-1:0]),
    .neg (neg_q_reg),
    .dout(quo_fix)
  );

  mdu_cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
    .din (acc_reg[2*WIDTH-1:WIDTH]),
    .neg (neg_r_reg),
    .dout(rem_fix)
  );
`endif

  // Shift-add multiply step: add multiplicand if LSB set, then shift right
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
               (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so the low WIDTH bits of the
  // difference are exact whenever the subtraction is taken.
  always_comb begin
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
    div_next  = div_ge ? {div_diff, acc_reg[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_div_reg <= 1'b0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      neg_q_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      fault_reg  <= 1'b0;
`ifdef MDU_DIV_EN
      neg_r_reg  <= 1'b0;
      divz_reg   <= 1'b0;
      a_raw_reg  <= '0;
`endif
    end else begin
      done_reg  <= 1'b0;
      fault_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg    <= '0;
            op_div_reg <= mdu_op_div(op);
            neg_q_reg  <= op_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            if (mdu_op_div(op)) begin
              acc_reg  <= {{WIDTH{1'b0}}, a_abs};
              opnd_reg <= b_abs;
            end else begin
              acc_reg  <= {{WIDTH{1'b0}}, b_abs};
              opnd_reg <= a_abs;
            end
`ifdef MDU_DIV_EN
            neg_r_reg  <= op_signed & srcA[WIDTH-1];
            divz_reg   <= (srcB == '0);
            a_raw_reg  <= srcA;
            state_reg  <= ST_CALC;
`else
            state_reg  <= mdu_op_div(op) ? ST_FIX : ST_CALC;
`endif
          end
        end
        ST_CALC: begin
`ifdef MDU_DIV_EN
          acc_reg <= op_div_reg ? div_next : mul_next;
`else
          acc_reg <= mul_next;
`endif
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'(MDU_ITERS - 1)) begin
            state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
          if (op_div_reg) begin
`ifdef MDU_DIV_EN
            if (divz_reg) begin
              lo_reg    <= '1;
              hi_reg    <= a_raw_reg;
              fault_reg <= 1'b1;
            end else begin
              lo_reg <= quo_fix;
              hi_reg <= rem_fix;
            end
`else
            fault_reg <= 1'b1;
`endif
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq.
// Expected results come from plain 64-bit / 32-bit arithmetic in a model task.
// Honours MDU_DIV_EN the same way as the design build.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy, done, fault;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Model state: architectural hi/lo plus expectations for the current op
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_fault = 1'b0;
  int          exp_lat = 33;

  mdu_seq #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .busy (busy),
    .done (done),
    .fault(fault),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Behavioural reference: results straight from arithmetic on the operands
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    exp_fault = 1'b0;
    exp_lat   = 33;
    if (o == MDU_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      {exp_hi, exp_lo} = p;
    end else if (o == MDU_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      {exp_hi, exp_lo} = up;
    end
`ifdef MDU_DIV_EN
    else if (b == 32'd0) begin
      exp_lo    = 32'hFFFF_FFFF;
      exp_hi    = a;
      exp_fault = 1'b1;
    end else if (o == MDU_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        exp_lo = 32'h8000_0000;
        exp_hi = 32'd0;
      end else begin
        exp_lo = 32'($signed(a) / $signed(b));
        exp_hi = 32'($signed(a) % $signed(b));
      end
    end else begin
      exp_lo = a / b;
      exp_hi = a % b;
    end
`else
    else begin
      // divider absent: hi/lo keep their value, fault raised one edge after E0
      exp_fault = 1'b1;
      exp_lat   = 1;
    end
`endif
  endtask

  // Operand generator biased towards corner values
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge, scramble operands after E0, wait for done.
  // Returns the number of edges from E0 to the edge that raised done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcA = $urandom; srcB = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 60);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fault, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b fault=%b hi=%h lo=%h, want all zero",
               busy, done, fault, hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, fault, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b fault=%b hi=%h lo=%h, want all zero",
               busy, done, fault, hi, lo);
    end
    exp_hi = '0; exp_lo = '0;
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult_vectors();
    int lat;
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    $display("MULTU ffffffff*ffffffff -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || lat != 33) begin
      errors++;
      $display("FAIL multu_max: got hi=%h lo=%h lat=%0d, want hi=fffffffe lo=00000001 lat=33",
               hi, lo, lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
    end
    do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, lat);
    $display("MULT -3*7 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || lat != 33 || fault !== 1'b0) begin
      errors++;
      $display("FAIL mult_neg: got hi=%h lo=%h lat=%0d fault=%b, want hi=ffffffff lo=ffffffeb lat=33 fault=0",
               hi, lo, lat, fault);
    end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div_vectors();
    logic [1:0]  vo [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vh [5];
    logic [31:0] vl [5];
    logic        vf [5];
    int lat;
    vo[0] = MDU_DIV;  va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;         vh[0] = 32'hFFFF_FFFF; vl[0] = 32'hFFFF_FFFD; vf[0] = 1'b0;
    vo[1] = MDU_DIVU; va[1] = 32'd100;       vb[1] = 32'd7;         vh[1] = 32'd2;         vl[1] = 32'd14;        vf[1] = 1'b0;
    vo[2] = MDU_DIVU; va[2] = 32'd5;         vb[2] = 32'd0;         vh[2] = 32'd5;         vl[2] = 32'hFFFF_FFFF; vf[2] = 1'b1;
    vo[3] = MDU_DIV;  va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; vh[3] = 32'd0;         vl[3] = 32'h8000_0000; vf[3] = 1'b0;
    vo[4] = MDU_DIV;  va[4] = 32'd7;         vb[4] = 32'hFFFF_FFFE; vh[4] = 32'd1;         vl[4] = 32'hFFFF_FFFD; vf[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], va[i], vb[i], lat);
      $display("div op=%0d a=%h b=%h -> hi=%h lo=%h fault=%b lat=%0d",
               vo[i], va[i], vb[i], hi, lo, fault, lat);
      checks++;
      if (hi !== vh[i] || lo !== vl[i] || fault !== vf[i] || lat != 33) begin
        errors++;
        $display("FAIL div_vec%0d: got hi=%h lo=%h fault=%b lat=%0d, want hi=%h lo=%h fault=%b lat=33",
                 i, hi, lo, fault, lat, vh[i], vl[i], vf[i]);
      end
      exp_hi = vh[i]; exp_lo = vl[i];
    end
  endtask
`else
  task automatic test_nodiv();
    int lat;
    do_op(MDU_MULTU, 32'd3, 32'd5, lat);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15 || lat != 33) begin
      errors++;
      $display("FAIL nodiv_setup: got hi=%h lo=%h lat=%0d, want hi=0 lo=f lat=33", hi, lo, lat);
    end
    @(negedge clk);
    do_op(MDU_DIV, 32'd9, 32'd3, lat);
    $display("DIV (no divider) 9/3 -> hi=%h lo=%h fault=%b lat=%0d busy=%b", hi, lo, fault, lat, busy);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15 || fault !== 1'b1 || lat != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nodiv_div: got hi=%h lo=%h fault=%b lat=%0d busy=%b, want hi=0 lo=f fault=1 lat=1 busy=0",
               hi, lo, fault, lat, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL nodiv_pulse: done=%b fault=%b one cycle later, want 0 0", done, fault);
    end
    exp_hi = 32'd0; exp_lo = 32'd15;
  endtask
`endif

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(o, a, b);
      do_op(o, a, b, lat);
      $display("rand%0d op=%0d a=%h b=%h -> hi=%h lo=%h fault=%b lat=%0d",
               i, o, a, b, hi, lo, fault, lat);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || fault !== exp_fault || lat != exp_lat) begin
        errors++;
        $display("FAIL rand%0d: got hi=%h lo=%h fault=%b lat=%0d, want hi=%h lo=%h fault=%b lat=%0d",
                 i, hi, lo, fault, lat, exp_hi, exp_lo, exp_fault, exp_lat);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_after: done=%b fault=%b busy=%b, want 0 0 0", i, done, fault, busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    int lat;
    int extra;
    a = $urandom; b = $urandom;
    model(MDU_MULT, a, b);
    op = MDU_MULT; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'($urandom); srcA = $urandom; srcB = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcA = $urandom; srcB = $urandom;
    lat = 5;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 60);
    $display("busy_ignore MULT a=%h b=%h -> hi=%h lo=%h lat=%0d", a, b, hi, lo, lat);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || lat != 33) begin
      errors++;
      $display("FAIL busy_ignore: got hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
               hi, lo, lat, exp_hi, exp_lo);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_queued: %0d cycles of busy/done after first result, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a, b;
    int lat;
    a = $urandom; b = $urandom;
    model(MDU_MULTU, a, b);
    do_op(MDU_MULTU, a, b, lat);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || lat != 33) begin
      errors++;
      $display("FAIL b2b_first: got hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
               hi, lo, lat, exp_hi, exp_lo);
    end
    o = 2'($urandom_range(0, 3)); a = pick(); b = pick();
    model(o, a, b);
    op = o; srcA = a; srcB = b; start = 1'b1;  // issued while done is high
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b after start in done cycle, want 0 1", done, busy);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 60);
    $display("b2b op=%0d a=%h b=%h -> hi=%h lo=%h fault=%b lat=%0d", o, a, b, hi, lo, fault, lat);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || fault !== exp_fault || lat != exp_lat) begin
      errors++;
      $display("FAIL b2b_second: got hi=%h lo=%h fault=%b lat=%0d, want hi=%h lo=%h fault=%b lat=%0d",
               hi, lo, fault, lat, exp_hi, exp_lo, exp_fault, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int seen;
    int lat;
    logic [31:0] a, b;
    op = MDU_MULT; srcA = $urandom; srcB = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("rst_mid: busy=%b done=%b fault=%b hi=%h lo=%h", busy, done, fault, hi, lo);
    checks++;
    if ({busy, done, fault, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b fault=%b hi=%h lo=%h, want all zero",
               busy, done, fault, hi, lo);
    end
    exp_hi = '0; exp_lo = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_done: saw %0d done pulses after abort, want 0", seen);
    end
    a = $urandom; b = $urandom;
    model(MDU_MULT, a, b);
    do_op(MDU_MULT, a, b, lat);
    $display("after rst MULT a=%h b=%h -> hi=%h lo=%h lat=%0d", a, b, hi, lo, lat);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || lat != 33) begin
      errors++;
      $display("FAIL rst_recover: got hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=33",
               hi, lo, lat, exp_hi, exp_lo);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult_vectors();
    @(negedge clk);
`ifdef MDU_DIV_EN
    test_div_vectors();
    @(negedge clk);
`else
    test_nodiv();
`endif
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
